// File: rtl/cond_logic_pipe.sv
// Pipelined conditional-execution unit for the execute stage.
// Evaluates the 16 condition codes against an architectural NZCV register,
// gates the decoder write intents and updates the flags with per-group
// enables. Stall holds all state, and flush squashes the instruction.
// Optional IT-block sequencer: define COND_IT_BLOCK_EN to compile it in.
module cond_logic_pipe #(
  parameter logic [3:0]  RESET_FLAGS   = 4'b0000,
  parameter bit          COND_F_ALWAYS = 1'b1,
  parameter int unsigned IT_MAX        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_e,
  input  logic       stall_e,
  input  logic       flush_e,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       it_start,
  input  logic [3:0] it_firstcond,
  input  logic [1:0] it_len,
  input  logic [2:0] it_te,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       it_active
);

  localparam logic [3:0] COND_AL = 4'hE;

  logic       go_c;
  logic       pass_c;
  logic [3:0] ec_c;
  logic [3:0] flags_q;
  logic [3:0] flags_d;

  // An instruction commits only when it is real, moving and not squashed
  assign go_c = valid_e & ~stall_e & ~flush_e & ~reset;

`ifdef COND_IT_BLOCK_EN
  localparam int unsigned SLOT_W  = 2;
  localparam logic [SLOT_W-1:0] LEN_MAX = SLOT_W'(IT_MAX - 1);

  typedef enum logic {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_e;

  it_state_e         state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] len_q, len_d;
  logic [3:0]        fc_q, fc_d;
  logic [2:0]        te_q, te_d;
  logic              then_c;
  logic [3:0]        slot_cond_c;

  // Slot condition: base condition, or its inverse for an else slot
  always_comb begin
    then_c = 1'b1;
    case (slot_q)
      2'd1:    then_c = te_q[0];
      2'd2:    then_c = te_q[1];
      2'd3:    then_c = te_q[2];
      default: then_c = 1'b1;
    endcase
    slot_cond_c = {fc_q[3:1], fc_q[0] ^ ~then_c};
  end

  // Effective condition: the IT instruction itself always executes
  always_comb begin
    ec_c = Cond;
    if (it_start) begin
      ec_c = COND_AL;
    end else if (state_q == IT_ACTIVE) begin
      ec_c = slot_cond_c;
    end
  end

  // IT sequencer next state: flush aborts, a new IT restarts the block
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    len_d   = len_q;
    fc_d    = fc_q;
    te_d    = te_q;
    if (valid_e && flush_e) begin
      state_d = IT_IDLE;
      slot_d  = '0;
    end else if (go_c) begin
      if (it_start) begin
        state_d = IT_ACTIVE;
        slot_d  = '0;
        fc_d    = it_firstcond;
        te_d    = it_te;
        len_d   = (it_len > LEN_MAX) ? LEN_MAX : it_len;
      end else if (state_q == IT_ACTIVE) begin
        if (slot_q == len_q) begin
          state_d = IT_IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
    end
  end

  // IT sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IT_IDLE;
      slot_q  <= '0;
      len_q   <= '0;
      fc_q    <= '0;
      te_q    <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      len_q   <= len_d;
      fc_q    <= fc_d;
      te_q    <= te_d;
    end
  end

  assign it_active = (state_q == IT_ACTIVE);
`else
  logic unused_it;

  // Without the sequencer every instruction uses its own condition
  assign ec_c      = Cond;
  assign it_active = 1'b0;
  assign unused_it = ^{it_start, it_firstcond, it_len, it_te, 32'(IT_MAX)};
`endif

  // Condition-code evaluation against the architectural flags
  always_comb begin
    pass_c = 1'b0;
    case (ec_c)
      4'h0:    pass_c = flags_q[2];
      4'h1:    pass_c = ~flags_q[2];
      4'h2:    pass_c = flags_q[1];
      4'h3:    pass_c = ~flags_q[1];
      4'h4:    pass_c = flags_q[3];
      4'h5:    pass_c = ~flags_q[3];
      4'h6:    pass_c = flags_q[0];
      4'h7:    pass_c = ~flags_q[0];
      4'h8:    pass_c = flags_q[1] & ~flags_q[2];
      4'h9:    pass_c = ~flags_q[1] | flags_q[2];
      4'hA:    pass_c = (flags_q[3] == flags_q[0]);
      4'hB:    pass_c = (flags_q[3] != flags_q[0]);
      4'hC:    pass_c = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'hD:    pass_c = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'hE:    pass_c = 1'b1;
      default: pass_c = COND_F_ALWAYS;
    endcase
  end

  // Per-group flag update for committed, condition-passing instructions
  always_comb begin
    flags_d = flags_q;
    if (go_c && pass_c) begin
      if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Architectural NZCV register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign Flags    = flags_q;
  assign CondEx   = pass_c;
  assign PCSrc    = PCS & pass_c & go_c;
  assign RegWrite = RegW & pass_c & ~NoWrite & go_c;
  assign MemWrite = MemW & pass_c & go_c;

endmodule

// File: tb/tb_cond_logic_pipe.sv
// Directed testbench for cond_logic_pipe with a scoreboard of expected
// outputs. IT-block steps are compiled only with COND_IT_BLOCK_EN.
module tb_cond_logic_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_e, stall_e, flush_e;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite;
  logic       it_start;
  logic [3:0] it_firstcond;
  logic [1:0] it_len;
  logic [2:0] it_te;

  logic       PCSrc, RegWrite, MemWrite, CondEx, it_active;
  logic [3:0] Flags;
  logic       PCSrc0, RegWrite0, MemWrite0, CondEx0, it_active0;
  logic [3:0] Flags0;

  always #5 clk = ~clk;

  cond_logic_pipe #(.RESET_FLAGS(4'b0100), .COND_F_ALWAYS(1'b1), .IT_MAX(4)) u_dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e), .flush_e(flush_e),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .it_start(it_start), .it_firstcond(it_firstcond),
    .it_len(it_len), .it_te(it_te), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .it_active(it_active)
  );

  cond_logic_pipe #(.RESET_FLAGS(4'b0000), .COND_F_ALWAYS(1'b0), .IT_MAX(4)) u_dut_f0 (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e), .flush_e(flush_e),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .it_start(it_start), .it_firstcond(it_firstcond),
    .it_len(it_len), .it_te(it_te), .PCSrc(PCSrc0), .RegWrite(RegWrite0),
    .MemWrite(MemWrite0), .CondEx(CondEx0), .Flags(Flags0), .it_active(it_active0)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;

  localparam int S_CONDEX = 0;
  localparam int S_PCSRC  = 1;
  localparam int S_REGW   = 2;
  localparam int S_MEMW   = 3;
  localparam int S_FLAGS  = 4;
  localparam int S_ITACT  = 5;
  localparam int S_F0_CEX = 6;

  // Reference condition table
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f, input bit f_always);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return f_always;
    endcase
  endfunction

  function automatic logic [3:0] observe(input int sel);
    case (sel)
      S_CONDEX: return {3'b000, CondEx};
      S_PCSRC:  return {3'b000, PCSrc};
      S_REGW:   return {3'b000, RegWrite};
      S_MEMW:   return {3'b000, MemWrite};
      S_FLAGS:  return Flags;
      S_ITACT:  return {3'b000, it_active};
      default:  return {3'b000, CondEx0};
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [3:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [3:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      n_checks++;
      assert (o === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  // Check at the falling edge, then commit on the rising edge
  task automatic step();
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_e = 0; stall_e = 0; flush_e = 0;
    Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    it_start = 0; it_firstcond = 4'h0; it_len = 2'd0; it_te = 3'b000;
  endtask

  task automatic set_flags(input logic [3:0] fv);
    idle();
    valid_e = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = fv;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    // Outputs forced low and flags held while reset is asserted
    valid_e = 1; PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11; ALUFlags = 4'hF;
    push_exp("rst_pcsrc", S_PCSRC, 4'h0);
    push_exp("rst_regw", S_REGW, 4'h0);
    push_exp("rst_memw", S_MEMW, 4'h0);
    push_exp("rst_flags", S_FLAGS, 4'h4);
    push_exp("rst_itact", S_ITACT, 4'h0);
    step();
    push_exp("rst_flags_hold", S_FLAGS, 4'h4);
    step();
    reset = 1'b0;
    idle();

    // EQ / NE with Z=1
    valid_e = 1; RegW = 1; Cond = 4'h0;
    push_exp("eq_condex", S_CONDEX, 4'h1);
    push_exp("eq_regw", S_REGW, 4'h1);
    step();
    Cond = 4'h1;
    push_exp("ne_condex", S_CONDEX, 4'h0);
    push_exp("ne_regw", S_REGW, 4'h0);
    step();
    Cond = 4'h0; NoWrite = 1;
    push_exp("nowrite_condex", S_CONDEX, 4'h1);
    push_exp("nowrite_regw", S_REGW, 4'h0);
    step();

    // Per-group flag writes
    idle();
    valid_e = 1; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'hA;
    push_exp("fw10_pre", S_FLAGS, 4'h4);
    step();
    FlagW = 2'b01; ALUFlags = 4'h7;
    push_exp("fw10_flags", S_FLAGS, 4'h8);
    step();
    idle();
    valid_e = 0; RegW = 1; FlagW = 2'b11; ALUFlags = 4'h0;
    push_exp("fw01_flags", S_FLAGS, 4'hB);
    push_exp("bubble_regw", S_REGW, 4'h0);
    step();
    valid_e = 1; Cond = 4'h0; ALUFlags = 4'h4;
    push_exp("bubble_flags", S_FLAGS, 4'hB);
    push_exp("failcond_condex", S_CONDEX, 4'h0);
    step();
    idle();
    push_exp("failcond_flags", S_FLAGS, 4'hB);
    step();

    // Walk all conditions over three flag patterns
    for (int k = 0; k < 3; k++) begin
      logic [3:0] fv;
      fv = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'h9;
      set_flags(fv);
      for (int c = 0; c < 16; c++) begin
        valid_e = 1; Cond = 4'(c);
        push_exp($sformatf("walk_f%0h_c%0h", fv, c), S_CONDEX, {3'b000, cond_ref(4'(c), fv, 1'b1)});
        push_exp($sformatf("walk_f0_f%0h_c%0h", fv, c), S_F0_CEX, {3'b000, cond_ref(4'(c), fv, 1'b0)});
        step();
      end
    end

    // Stall blocks writes and flags; release lets them through
    idle();
    valid_e = 1; PCS = 1; MemW = 1; Cond = 4'hA; stall_e = 1; FlagW = 2'b11; ALUFlags = 4'h0;
    push_exp("stall_condex", S_CONDEX, 4'h1);
    push_exp("stall_pcsrc", S_PCSRC, 4'h0);
    push_exp("stall_memw", S_MEMW, 4'h0);
    step();
    stall_e = 0; FlagW = 2'b00;
    push_exp("stall_flags", S_FLAGS, 4'h9);
    push_exp("rel_pcsrc", S_PCSRC, 4'h1);
    push_exp("rel_memw", S_MEMW, 4'h1);
    step();
    stall_e = 1; flush_e = 1; FlagW = 2'b11;
    push_exp("flushstall_pcsrc", S_PCSRC, 4'h0);
    step();
    idle();
    push_exp("flushstall_flags", S_FLAGS, 4'h9);
    step();

`ifdef COND_IT_BLOCK_EN
    set_flags(4'h4);
    // IT EQ, len 3, slots EQ NE EQ
    valid_e = 1; RegW = 1; Cond = 4'h1;
    it_start = 1; it_firstcond = 4'h0; it_len = 2'd2; it_te = 3'b010;
    push_exp("it_instr_condex", S_CONDEX, 4'h1);
    push_exp("it_instr_regw", S_REGW, 4'h1);
    push_exp("it_pre_active", S_ITACT, 4'h0);
    step();
    idle();
    valid_e = 1; RegW = 1; Cond = 4'hE;
    push_exp("it_s0_regw", S_REGW, 4'h1);
    push_exp("it_s0_active", S_ITACT, 4'h1);
    step();
    valid_e = 0;
    push_exp("it_bubble_regw", S_REGW, 4'h0);
    push_exp("it_bubble_active", S_ITACT, 4'h1);
    step();
    valid_e = 1;
    push_exp("it_s1_regw", S_REGW, 4'h0);
    push_exp("it_s1_condex", S_CONDEX, 4'h0);
    step();
    push_exp("it_s2_regw", S_REGW, 4'h1);
    push_exp("it_s2_active", S_ITACT, 4'h1);
    step();
    Cond = 4'h1;
    push_exp("it_done_active", S_ITACT, 4'h0);
    push_exp("it_done_regw", S_REGW, 4'h0);
    step();
    Cond = 4'h0;
    push_exp("it_done_own_regw", S_REGW, 4'h1);
    step();

    // Flush mid-block aborts the sequencer
    idle();
    valid_e = 1; RegW = 1;
    it_start = 1; it_firstcond = 4'h1; it_len = 2'd3; it_te = 3'b111;
    push_exp("itf_instr_regw", S_REGW, 4'h1);
    step();
    idle();
    valid_e = 1; RegW = 1; Cond = 4'h0;
    push_exp("itf_s0_regw", S_REGW, 4'h0);
    push_exp("itf_s0_active", S_ITACT, 4'h1);
    step();
    flush_e = 1;
    push_exp("itf_flush_regw", S_REGW, 4'h0);
    step();
    flush_e = 0;
    push_exp("itf_after_active", S_ITACT, 4'h0);
    push_exp("itf_after_regw", S_REGW, 4'h1);
    step();

    // Asynchronous reset mid-block
    idle();
    valid_e = 1; RegW = 1; FlagW = 2'b11; ALUFlags = 4'h0;
    it_start = 1; it_firstcond = 4'h0; it_len = 2'd3; it_te = 3'b111;
    step();
    idle();
    valid_e = 1; RegW = 1;
    push_exp("itr_s0_active", S_ITACT, 4'h1);
    push_exp("itr_s0_flags", S_FLAGS, 4'h0);
    step();
    #2;
    reset = 1'b1;
    #1;
    push_exp("itr_async_active", S_ITACT, 4'h0);
    push_exp("itr_async_flags", S_FLAGS, 4'h4);
    push_exp("itr_async_regw", S_REGW, 4'h0);
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    push_exp("itr_post_active", S_ITACT, 4'h0);
    step();
`else
    // Sequencer absent: IT inputs are ignored, Cond is used directly
    idle();
    valid_e = 1; RegW = 1; Cond = 4'h0;
    it_start = 1; it_firstcond = 4'h0; it_len = 2'd2; it_te = 3'b111;
    push_exp("noit_condex", S_CONDEX, 4'h0);
    push_exp("noit_regw", S_REGW, 4'h0);
    push_exp("noit_active", S_ITACT, 4'h0);
    step();
    it_start = 0;
    push_exp("noit_next_regw", S_REGW, 4'h0);
    push_exp("noit_next_active", S_ITACT, 4'h0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cond_logic_pipe.md
# cond_logic_pipe

Pipelined, parametrised successor to the single-cycle conditional logic unit. It sits in the execute stage of the pipelined core. It evaluates all 16 condition codes against an architectural NZCV flag register and gates PCSrc, RegWrite and MemWrite for each instruction. It updates the flags with per-group write enables and honours pipeline stall and flush. An optional IT-block sequencer applies a condition to up to four following instructions.

## Interface
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset
- COND_F_ALWAYS, 1, 1: Cond=4'hF behaves as AL; 0: never executes
- IT_MAX, 4, maximum IT block length (1..4)
- Reset is asynchronous and active-high; `reset` clears state immediately, independent of `clk`.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- valid_e  in  1  execute stage holds a real instruction
- stall_e  in  1  execute stage held this cycle
- flush_e  in  1  execute instruction squashed this cycle
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle
- FlagW  in  2  [1]: update N,Z; [0]: update C,V
- PCS, RegW, MemW, NoWrite  in  1 each  decoder write intents
- it_start  in  1  execute instruction is an IT instruction
- it_firstcond  in  4  IT base condition
- it_len  in  2  block length minus 1
- it_te  in  3  then(1)/else(0) for slots 1..3
- PCSrc, RegWrite, MemWrite  out  1 each  gated write enables
- CondEx  out  1  condition passed, before gating
- Flags  out  4  architectural NZCV register
- it_active  out  1  IT block in progress

## Operation
- Effective condition (ec) is Cond, or the IT slot condition while it_active.
- Condition evaluation on Flags (N=3, Z=2, C=1, V=0):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F per COND_F_ALWAYS
- go = valid_e & !stall_e & !flush_e & !reset.
- PCSrc = PCS&CondEx&go; RegWrite = RegW&CondEx&!NoWrite&go; MemWrite = MemW&CondEx&go.
- Flag update at the clock edge when go&CondEx: Flags[3:2]<=ALUFlags[3:2] if FlagW[1]; Flags[1:0]<=ALUFlags[1:0] if FlagW[0]. Unselected bits hold.
- IT sequencer, states IDLE/ACTIVE plus slot counter (0..IT_MAX-1):
  - IDLE: go&it_start -> ACTIVE, slot=0, latch firstcond, len, te. The IT instruction itself is unconditional (ec=AL).
  - ACTIVE: slot 0 uses firstcond. Slot k uses firstcond if te[k-1]=1, else firstcond with bit0 inverted.
  - ACTIVE, each go: slot++. The transition after slot==len returns to IDLE.
  - it_len is clamped to IT_MAX-1.
  - A failed condition still consumes a slot.

## Timing
- PCSrc, RegWrite, MemWrite and CondEx are combinational from inputs, Flags and IT state; no added latency.
- Flags and IT state update on the rising edge. A flag write is visible to the next instruction's condition in the following cycle.
- Reset values: Flags=RESET_FLAGS, IDLE, slot=0, it_active=0. PCSrc, RegWrite and MemWrite are 0 while reset is high.
- stall_e: write enables are 0, and Flags and IT state hold.
- flush_e: write enables are 0 and Flags hold. IT state aborts to IDLE on the edge.
- stall_e and flush_e together: flush wins.
- it_start while ACTIVE (and go): the block restarts at slot 0 with the new parameters; the old block is discarded.
- valid_e=0: no state change and outputs are 0. IT slots advance only on go.

## Configuration
- COND_IT_BLOCK_EN defined: IT sequencer is compiled in as described above.
- Not defined:
  - it_start, it_firstcond, it_len and it_te are ignored.
  - it_active is tied to 0.
  - ec is always Cond.
  - All other behaviour is identical.

## Test plan
- Reset with RESET_FLAGS=4'b0100, then Cond=0 (EQ), RegW=1, valid_e=1 -> CondEx=1, RegWrite=1. Same with Cond=1 (NE) -> RegWrite=0.
- ALUFlags=4'hA, FlagW=2'b10, Cond=E: the next cycle shows Flags={1,0,C_old,V_old}. With FlagW=2'b01, only C,V change.
- Walk all 16 Cond values with Flags set to 4'h0, 4'hF and 4'h9 -> CondEx matches the table. Cond=F with COND_F_ALWAYS=0 -> 0 regardless of flags.
- PCS=1, MemW=1, condition true, stall_e=1 -> PCSrc=0, MemWrite=0, Flags unchanged. Releasing the stall gives PCSrc=1, MemWrite=1.
- With COND_IT_BLOCK_EN: it_start, firstcond=0 (EQ), len=2, te=3'b010, Z=1. The three following instructions see ec=EQ, NE, EQ, giving RegWrite=1,0,1, then it_active drops.
- With COND_IT_BLOCK_EN: flush_e asserted mid-block at slot 1 -> it_active=0 the next cycle and the next instruction uses its own Cond. Asserting reset mid-block asynchronously gives it_active=0 and Flags=RESET_FLAGS.
